// File: rtl/display_control_pkg.sv
// -----------------------------------------------------------------------------
// display_control_pkg
// Shared definitions for the clock/alarm seven-segment display path:
//   - SEG_TABLE_AL : 16-entry active-low segment codes (gfedcba), hex 0-F
//   - BLANK_AL     : active-low code with no segment lit
//   - disp_mode_e  : which source pair feeds the four digits
//   - seg_code()   : table lookup with polarity applied
// -----------------------------------------------------------------------------
package display_control_pkg;

  // Bit 6 = g ... bit 0 = a. A 0 bit lights the segment.
  localparam logic [6:0] SEG_TABLE_AL [16] = '{
    7'h40, // 0
    7'h79, // 1
    7'h24, // 2
    7'h30, // 3
    7'h19, // 4
    7'h12, // 5
    7'h02, // 6
    7'h78, // 7
    7'h00, // 8
    7'h10, // 9
    7'h08, // A
    7'h03, // b
    7'h46, // C
    7'h21, // d
    7'h06, // E
    7'h0E  // F
  };

  localparam logic [6:0] BLANK_AL = 7'h7F;

  typedef enum logic [1:0] {
    MODE_HM    = 2'd0, // hours:minutes
    MODE_MS    = 2'd1, // minutes:seconds
    MODE_ALARM = 2'd2  // alarm hours:minutes
  } disp_mode_e;

  // Look up a nibble and apply output polarity (active_low=0 inverts).
  function automatic logic [6:0] seg_code(input logic [3:0] nibble,
                                          input logic       active_low);
    logic [6:0] code;
    code = SEG_TABLE_AL[nibble];
    return active_low ? code : ~code;
  endfunction

  // Blank pattern for the given polarity.
  function automatic logic [6:0] blank_code(input logic active_low);
    return active_low ? BLANK_AL : ~BLANK_AL;
  endfunction

endpackage

// File: rtl/display_control_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Purely combinational hex-to-seven-segment decoder. Every nibble value 0-F
// is shown as its hex glyph; nothing is blanked here.
// Parameters:
//   SEG_ACTIVE_LOW : 1 = lit segment drives 0, 0 = lit segment drives 1
// Ports:
//   nibble_i [3:0] : value to display
//   seg_o    [6:0] : segment code, bit 6 = g ... bit 0 = a
// -----------------------------------------------------------------------------
module seg7_decode
  import display_control_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_code(nibble_i, SEG_ACTIVE_LOW);

endmodule

// File: rtl/display_control.sv
// -----------------------------------------------------------------------------
// display_control
// Selects one of three packed-BCD time pairs, decodes the four nibbles to
// seven-segment codes and registers them so all digits change on one edge.
// Configuration macro:
//   DISPLAY_CONTROL_LEADING_BLANK_EN : when defined, HEX3 is blanked if the
//                                      selected left tens nibble is 0.
// Parameters:
//   SEG_ACTIVE_LOW : 1 = lit segment drives 0 (default), 0 = drives 1
// Ports:
//   CP1         : clock, rising edge
//   CR          : asynchronous active-high reset, blanks all digits
//   Hour        [7:0] : current hour, packed BCD
//   Minutes     [7:0] : current minutes, packed BCD
//   Second      [7:0] : current seconds, packed BCD
//   AHour       [7:0] : alarm hour, packed BCD
//   AMinutes    [7:0] : alarm minutes, packed BCD
//   SwitchMHToS       : 0 = hours:minutes, 1 = minutes:seconds
//   DisplayA          : 1 = alarm time (overrides SwitchMHToS)
//   HEX3..HEX0  [6:0] : digit codes, HEX3 leftmost
// -----------------------------------------------------------------------------
module display_control
  import display_control_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CP1,
  input  logic       CR,
  input  logic [7:0] Hour,
  input  logic [7:0] Minutes,
  input  logic [7:0] Second,
  input  logic [7:0] AHour,
  input  logic [7:0] AMinutes,
  input  logic       SwitchMHToS,
  input  logic       DisplayA,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  localparam logic [6:0] BLANK = blank_code(SEG_ACTIVE_LOW);

  disp_mode_e mode_d;
  logic [7:0] left_d;
  logic [7:0] right_d;
  logic [6:0] dec3, dec2, dec1, dec0;
  logic [6:0] hex3_d, hex2_d, hex1_d, hex0_d;
  logic [6:0] hex3_q, hex2_q, hex1_q, hex0_q;

  // Mode priority: alarm display wins over the seconds switch.
  always_comb begin
    mode_d = MODE_HM;
    if (DisplayA) begin
      mode_d = MODE_ALARM;
    end else if (SwitchMHToS) begin
      mode_d = MODE_MS;
    end
  end

  always_comb begin
    left_d  = Hour;
    right_d = Minutes;
    case (mode_d)
      MODE_HM: begin
        left_d  = Hour;
        right_d = Minutes;
      end
      MODE_MS: begin
        left_d  = Minutes;
        right_d = Second;
      end
      MODE_ALARM: begin
        left_d  = AHour;
        right_d = AMinutes;
      end
      default: begin
        left_d  = Hour;
        right_d = Minutes;
      end
    endcase
  end

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec3 (
    .nibble_i (left_d[7:4]),
    .seg_o    (dec3)
  );

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec2 (
    .nibble_i (left_d[3:0]),
    .seg_o    (dec2)
  );

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec1 (
    .nibble_i (right_d[7:4]),
    .seg_o    (dec1)
  );

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec0 (
    .nibble_i (right_d[3:0]),
    .seg_o    (dec0)
  );

  // Leading-zero suppression applies to the leftmost digit only.
  always_comb begin
`ifdef DISPLAY_CONTROL_LEADING_BLANK_EN
    hex3_d = (left_d[7:4] == 4'd0) ? BLANK : dec3;
`else
    hex3_d = dec3;
`endif
    hex2_d = dec2;
    hex1_d = dec1;
    hex0_d = dec0;
  end

  // All four digits share one register stage so a mode switch never shows
  // digits from two different source pairs.
  always_ff @(posedge CP1 or posedge CR) begin
    if (CR) begin
      hex3_q <= BLANK;
      hex2_q <= BLANK;
      hex1_q <= BLANK;
      hex0_q <= BLANK;
    end else begin
      hex3_q <= hex3_d;
      hex2_q <= hex2_d;
      hex1_q <= hex1_d;
      hex0_q <= hex0_d;
    end
  end

  assign HEX3 = hex3_q;
  assign HEX2 = hex2_q;
  assign HEX1 = hex1_q;
  assign HEX0 = hex0_q;

endmodule

// File: tb/tb_display_control.sv
// -----------------------------------------------------------------------------
// tb_display_control
// Directed, table-driven bench for display_control. Two instances share the
// same stimulus: one active-low (default) and one active-high, whose outputs
// must be the bitwise inverse of the active-low expectations.
// -----------------------------------------------------------------------------
module tb_display_control;

  // Clock / reset ------------------------------------------------------------
  logic       CP1;
  logic       CR;
  logic [7:0] Hour, Minutes, Second, AHour, AMinutes;
  logic       SwitchMHToS, DisplayA;
  logic [6:0] hex3_l, hex2_l, hex1_l, hex0_l;
  logic [6:0] hex3_h, hex2_h, hex1_h, hex0_h;

  initial CP1 = 1'b0;
  always #5 CP1 = ~CP1;

  display_control #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
    .CP1         (CP1),
    .CR          (CR),
    .Hour        (Hour),
    .Minutes     (Minutes),
    .Second      (Second),
    .AHour       (AHour),
    .AMinutes    (AMinutes),
    .SwitchMHToS (SwitchMHToS),
    .DisplayA    (DisplayA),
    .HEX3        (hex3_l),
    .HEX2        (hex2_l),
    .HEX1        (hex1_l),
    .HEX0        (hex0_l)
  );

  display_control #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
    .CP1         (CP1),
    .CR          (CR),
    .Hour        (Hour),
    .Minutes     (Minutes),
    .Second      (Second),
    .AHour       (AHour),
    .AMinutes    (AMinutes),
    .SwitchMHToS (SwitchMHToS),
    .DisplayA    (DisplayA),
    .HEX3        (hex3_h),
    .HEX2        (hex2_h),
    .HEX1        (hex1_h),
    .HEX0        (hex0_h)
  );

  // Reference glyph table (active-low gfedcba) ------------------------------
  logic [6:0] ref_tab [16];
  initial begin
    ref_tab[0]  = 7'h40; ref_tab[1]  = 7'h79; ref_tab[2]  = 7'h24; ref_tab[3]  = 7'h30;
    ref_tab[4]  = 7'h19; ref_tab[5]  = 7'h12; ref_tab[6]  = 7'h02; ref_tab[7]  = 7'h78;
    ref_tab[8]  = 7'h00; ref_tab[9]  = 7'h10; ref_tab[10] = 7'h08; ref_tab[11] = 7'h03;
    ref_tab[12] = 7'h46; ref_tab[13] = 7'h21; ref_tab[14] = 7'h06; ref_tab[15] = 7'h0E;
  end

  // Vector table -------------------------------------------------------------
  typedef struct {
    logic [7:0] hour, minutes, second, ahour, amin;
    logic       sw, da;
    logic [6:0] e3, e2, e1, e0;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic [7:0] ah,
                              input logic [7:0] am, input logic sw,
                              input logic da, input logic [6:0] e3,
                              input logic [6:0] e2, input logic [6:0] e1,
                              input logic [6:0] e0);
    vec_t v;
    v.hour = h; v.minutes = m; v.second = s; v.ahour = ah; v.amin = am;
    v.sw = sw; v.da = da; v.e3 = e3; v.e2 = e2; v.e1 = e1; v.e0 = e0;
    return v;
  endfunction

  // Scoreboard ---------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [6:0] act,
                     input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Checks both instances against active-low expectations.
  task automatic chk_all(input string tag, input logic [6:0] e3,
                         input logic [6:0] e2, input logic [6:0] e1,
                         input logic [6:0] e0);
    chk({tag, " L.HEX3"}, hex3_l, e3);
    chk({tag, " L.HEX2"}, hex2_l, e2);
    chk({tag, " L.HEX1"}, hex1_l, e1);
    chk({tag, " L.HEX0"}, hex0_l, e0);
    chk({tag, " H.HEX3"}, hex3_h, ~e3);
    chk({tag, " H.HEX2"}, hex2_h, ~e2);
    chk({tag, " H.HEX1"}, hex1_h, ~e1);
    chk({tag, " H.HEX0"}, hex0_h, ~e0);
  endtask

  // Driver tasks -------------------------------------------------------------
  task automatic tick();
    @(posedge CP1);
    #1;
  endtask

  task automatic drive(input vec_t v);
    Hour = v.hour; Minutes = v.minutes; Second = v.second;
    AHour = v.ahour; AMinutes = v.amin;
    SwitchMHToS = v.sw; DisplayA = v.da;
  endtask

  // Leading-blank expectation for HEX3 when the option is built in.
  function automatic logic [6:0] exp_hex3(input vec_t v);
    logic [3:0] tens;
    tens = v.da ? v.ahour[7:4] : (v.sw ? v.minutes[7:4] : v.hour[7:4]);
`ifdef DISPLAY_CONTROL_LEADING_BLANK_EN
    if (tens == 4'd0) return 7'h7F;
`endif
    if (tens == 4'hF) return v.e3; // keep the table value; tens only gates blanking
    return v.e3;
  endfunction

  logic [6:0] cur3, cur2, cur1, cur0;
  logic [7:0] nn;

  // Test sequence ------------------------------------------------------------
  initial begin
    //            Hour   Min    Sec    AHour  AMin   sw    da    HEX3   HEX2   HEX1   HEX0
    vecs[0] = mk(8'h91, 8'h51, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 7'h10, 7'h79, 7'h12, 7'h79);
    vecs[1] = mk(8'h91, 8'h51, 8'h91, 8'h00, 8'h00, 1'b1, 1'b0, 7'h12, 7'h79, 7'h10, 7'h79);
    vecs[2] = mk(8'h91, 8'h51, 8'h91, 8'h31, 8'h51, 1'b1, 1'b1, 7'h30, 7'h79, 7'h12, 7'h79);
    vecs[3] = mk(8'h0A, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 7'h40, 7'h08, 7'h0E, 7'h0E);
    vecs[4] = mk(8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 1'b0, 1'b0, 7'h24, 7'h30, 7'h19, 7'h12);
    vecs[5] = mk(8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 1'b1, 1'b0, 7'h19, 7'h12, 7'h02, 7'h78);
    vecs[6] = mk(8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 1'b0, 1'b1, 7'h00, 7'h10, 7'h08, 7'h03);
    vecs[7] = mk(8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 7'h46, 7'h21, 7'h06, 7'h0E);
    vecs[8] = mk(8'h08, 8'h00, 8'h59, 8'h07, 8'h30, 1'b0, 1'b0, 7'h40, 7'h00, 7'h40, 7'h40);

    // Reset: outputs blank while CR is high, before any clock edge matters.
    CR = 1'b0;
    drive(vecs[0]);
    #1 CR = 1'b1;
    #1;
    chk_all("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    @(negedge CP1);
    CR = 1'b0;
    #1;
    chk_all("post_reset_pre_edge", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Table-driven vectors: apply, one edge, compare.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      tick();
      cur3 = exp_hex3(vecs[i]);
      cur2 = vecs[i].e2;
      cur1 = vecs[i].e1;
      cur0 = vecs[i].e0;
      chk_all($sformatf("vec%0d", i), cur3, cur2, cur1, cur0);
    end

    // Latency: switch to minutes:seconds and confirm nothing moves before the edge.
    drive(vecs[0]);
    tick();
    drive(vecs[1]);
    #2;
    chk_all("ms_pre_edge", exp_hex3(vecs[0]), vecs[0].e2, vecs[0].e1, vecs[0].e0);
    tick();
    cur3 = exp_hex3(vecs[1]); cur2 = vecs[1].e2; cur1 = vecs[1].e1; cur0 = vecs[1].e0;
    chk_all("ms_post_edge", cur3, cur2, cur1, cur0);

    // Mid-operation reset pulse between edges.
    #1 CR = 1'b1;
    #1;
    chk_all("mid_reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    #2 CR = 1'b0;
    #1;
    chk_all("mid_reset_released", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    tick();
    chk_all("mid_reset_reload", cur3, cur2, cur1, cur0);

    // Sweep every nibble value on every digit position.
    for (int n = 0; n < 16; n++) begin
      nn = {n[3:0], n[3:0]};
      Hour = nn; Minutes = nn; Second = 8'h00; AHour = 8'h00; AMinutes = 8'h00;
      SwitchMHToS = 1'b0; DisplayA = 1'b0;
      tick();
      cur3 = ref_tab[n];
`ifdef DISPLAY_CONTROL_LEADING_BLANK_EN
      if (n == 0) cur3 = 7'h7F;
`endif
      chk_all($sformatf("sweep%0h", n), cur3, ref_tab[n], ref_tab[n], ref_tab[n]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_control.md
DISPLAY_CONTROL -- requirements
Module: display_control

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1; 1 = a lit segment drives 0, 0 = a lit segment drives 1.
REQ-002 CP1 input 1: the single clock; all state updates on its rising edge.
REQ-003 CR input 1: reset, asynchronous, active-high.
REQ-004 Hour input 8: current hour, packed BCD ([7:4] tens, [3:0] units).
REQ-005 Minutes input 8: current minutes, packed BCD.
REQ-006 Second input 8: current seconds, packed BCD.
REQ-007 AHour input 8: alarm hour, packed BCD.
REQ-008 AMinutes input 8: alarm minutes, packed BCD.
REQ-009 SwitchMHToS input 1: 0 = show hours:minutes, 1 = show minutes:seconds.
REQ-010 DisplayA input 1: 1 = show the alarm time.
REQ-011 HEX3 output 7: seven-segment code for the leftmost digit; bit 6 = g ... bit 0 = a.
REQ-012 HEX2, HEX1 and HEX0 outputs 7 each: codes for the next digits to the right; HEX0 is the rightmost digit.

Function
REQ-013 Source pair select: DisplayA=1 selects {AHour, AMinutes}, overriding SwitchMHToS; otherwise SwitchMHToS=1 selects {Minutes, Second}; otherwise {Hour, Minutes}.
REQ-014 Digit mapping: HEX3 = left[7:4], HEX2 = left[3:0], HEX1 = right[7:4], HEX0 = right[3:0].
REQ-015 Each nibble is decoded as full hexadecimal 0-F; invalid BCD nibbles are displayed as A-F, not blanked.
REQ-016 Active-low codes, as gfedcba in hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-017 With SEG_ACTIVE_LOW=0, every output is the bitwise inverse of the REQ-016 code.
REQ-018 Outputs are registered: a change on any input appears on HEX0-HEX3 at the first rising CP1 edge after it, i.e. 1-cycle latency.
REQ-019 All four outputs update on the same edge; mixed digits from two different source pairs never appear.
REQ-020 Mode inputs and data inputs that change together are sampled on the same edge.

Reset
REQ-021 While CR=1, all outputs are immediately blank (no segment lit: 7F active-low, 00 active-high), independent of CP1.
REQ-022 After CR falls, the first rising CP1 edge loads decoded data.
REQ-023 A reset asserted mid-operation blanks the display at once; no other state is retained.

Configuration
REQ-024 Macro DISPLAY_CONTROL_LEADING_BLANK_EN.
- Defined: HEX3 is blank when the selected left tens nibble is 0 (e.g. hour 08 shows " 8").
- Not defined: HEX3 always shows its digit, including 0.

Structure
REQ-025 A shared package holds the 16-entry segment code table, the blank constant and a 2-bit display-mode enum (HM, MS, ALARM).
REQ-026 One combinational sub-module, seg7_decode (4-bit nibble in, 7-bit code out, polarity parameter), is instantiated four times.
REQ-027 The top level holds the mode mux, the blanking logic and the output registers only.

Verification
REQ-028 Hour=91, Minutes=51, SwitchMHToS=0, DisplayA=0, one edge -> HEX3=10, HEX2=79, HEX1=12, HEX0=79.
REQ-029 Same data, SwitchMHToS=1, Second=91 -> HEX3=12, HEX2=79, HEX1=10, HEX0=79 after one edge, unchanged before that edge.
REQ-030 DisplayA=1, SwitchMHToS=1, AHour=31, AMinutes=51 -> HEX3=30, HEX2=79, HEX1=12, HEX0=79.
REQ-031 CR pulsed high between clock edges -> all outputs 7F immediately; decoded values return on the first edge after CR falls.
REQ-032 Hour=0A, Minutes=FF -> HEX3=40 (blank 7F with the macro defined), HEX2=08, HEX1=0E, HEX0=0E.
REQ-033 Sweep each nibble 0-F on every digit position -> every output matches the REQ-016 table.
